// File: rtl/array_row_sequencer.sv
// Sequential multiply/divide engine: one array row (shift-add or restoring subtract) per clock.
// Latency N cycles from accepted START to DONE; START is ignored while BUSY, no queueing.
module array_row_sequencer #(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           mul_bar_i,
  input  logic [N-1:0]   x_in_i,
  input  logic [N-1:0]   y_in_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] result_o,
  output logic           div0_o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             divz_q, divz_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     opb_q, opb_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N:0]       rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [2*N-1:0]   result_q, result_d;
  logic             div0_q, div0_d;

  logic [2*N-1:0]   prod_acc;
  logic [N+1:0]     rem_sh;
  logic [N+1:0]     trial;
  logic [N:0]       rem_new;
  logic [N-1:0]     quo_new;

  // Row datapath: mcand shifts left / multiplier right; dividend shifts out MSB first.
  always_comb begin
    prod_acc = acc_q + (opb_q[0] ? mcand_q : '0);
    rem_sh   = {rem_q, opb_q[N-1]};
    trial    = rem_sh - {2'b00, mcand_q[N-1:0]};
    rem_new  = trial[N+1] ? rem_sh[N:0] : trial[N:0];
    quo_new  = {quo_q[N-2:0], ~trial[N+1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    divz_d   = divz_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    div0_d   = div0_q;

    if (state_q == S_RUN) begin
      if (mode_q) begin
        rem_d = rem_new;
        quo_d = quo_new;
        opb_d = opb_q << 1;
      end else begin
        acc_d   = prod_acc;
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
      end
      if (cnt_q == LAST) begin
        state_d = S_FIN;
        div0_d  = mode_q & divz_q;
        if (!mode_q)
          result_d = prod_acc;
        else if (divz_q)
          result_d = {rem_new[N-1:0], {N{1'b1}}};
        else
          result_d = {rem_new[N-1:0], quo_new};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (start_i) begin
      state_d = S_RUN;
      cnt_d   = '0;
      mode_d  = mul_bar_i;
      divz_d  = (x_in_i == '0);
      mcand_d = {{N{1'b0}}, x_in_i};
      opb_d   = y_in_i;
      acc_d   = '0;
      rem_d   = '0;
      quo_d   = '0;
      div0_d  = 1'b0;
    end else if (state_q == S_FIN) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      divz_q   <= 1'b0;
      mcand_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      divz_q   <= divz_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      div0_q   <= div0_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_FIN);
  assign result_o = result_q;
  assign div0_o   = div0_q;

endmodule

// File: tb/tb_array_row_sequencer.sv
// Bench for array_row_sequencer (N=4): directed table, handshake/reset sequences, random ops vs arithmetic model.
module tb_array_row_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, start, mb;
  logic [3:0] x, y;
  logic       busy, done, div0;
  logic [7:0] result;

  int n_pass  = 0;
  int n_total = 0;

  array_row_sequencer #(.N(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mul_bar_i(mb),
    .x_in_i(x), .y_in_i(y), .busy_o(busy), .done_o(done),
    .result_o(result), .div0_o(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] er;
    logic       ed;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [7:0] ref_result(input logic m, input logic [3:0] a, input logic [3:0] b);
    int p, q, r;
    if (!m) begin
      p = int'(a) * int'(b);
      return p[7:0];
    end
    if (a == 0) return {b, 4'hF};
    q = int'(b) / int'(a);
    r = int'(b) % int'(a);
    return {r[3:0], q[3:0]};
  endfunction

  function automatic logic ref_div0(input logic m, input logic [3:0] a);
    return m && (a == 0);
  endfunction

  // Drives START for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic m, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; mb = m; x = a; y = b;
    @(negedge clk);
    start = 1'b0;
    x  = 4'($urandom);
    y  = 4'($urandom);
    mb = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic finish_op(input string nm, input logic [7:0] er, input logic ed);
    int  bc;
    bit  ok;
    wait_done(bc, ok);
    check({nm, " done seen"}, 32'(ok), 32'd1);
    check({nm, " busy cycles"}, 32'(bc), 32'd4);
    check({nm, " result"}, 32'(result), 32'(er));
    check({nm, " div0"}, 32'(div0), 32'(ed));
    @(negedge clk);
    check({nm, " done pulse width"}, 32'(done), 32'd0);
    check({nm, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vt[7];
    int   dones;
    logic [7:0] res;

    vt[0] = '{1'b0, 4'd13, 4'd11, 8'h8F, 1'b0};
    vt[1] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0};
    vt[2] = '{1'b0, 4'd0,  4'd9,  8'h00, 1'b0};
    vt[3] = '{1'b1, 4'd3,  4'd13, 8'h14, 1'b0};
    vt[4] = '{1'b1, 4'd5,  4'd3,  8'h30, 1'b0};
    vt[5] = '{1'b1, 4'd0,  4'd7,  8'h7F, 1'b1};
    vt[6] = '{1'b0, 4'd2,  4'd3,  8'h06, 1'b0};

    rst = 1'b1; start = 1'b0; mb = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset div0", 32'(div0), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(vt[i].m, vt[i].a, vt[i].b);
      if (i == 6) check("div0 cleared on start", 32'(div0), 32'd0);
      finish_op($sformatf("vec%0d", i), vt[i].er, vt[i].ed);
    end

    // START two cycles into an operation must be ignored.
    issue(1'b0, 4'd13, 4'd11);
    dones = 0;
    res = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin start = 1'b1; x = 4'd15; y = 4'd15; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin dones++; res = result; end
    end
    start = 1'b0;
    check("ignored start result", 32'(res), 32'h8F);
    check("ignored start done count", 32'(dones), 32'd1);

    // START during FIN is accepted back-to-back.
    issue(1'b0, 4'd13, 4'd11);
    begin
      int bc;
      bit ok;
      wait_done(bc, ok);
      check("b2b first done", 32'(ok), 32'd1);
      check("b2b first result", 32'(result), 32'h8F);
    end
    start = 1'b1; mb = 1'b1; x = 4'd3; y = 4'd13;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy at accept", 32'(busy), 32'd1);
    check("b2b done dropped", 32'(done), 32'd0);
    finish_op("b2b second", 8'h14, 1'b0);

    // Reset in the middle of a multiply aborts it without a DONE.
    issue(1'b0, 4'd13, 4'd11);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort done", 32'(done), 32'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    issue(1'b0, 4'd13, 4'd11);
    finish_op("after abort", 8'h8F, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic       m;
      logic [3:0] a, b;
      m = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      if (i % 10 == 0) a = 4'd0;
      issue(m, a, b);
      finish_op($sformatf("rand%0d m%0d %0d,%0d", i, m, a, b), ref_result(m, a, b), ref_div0(m, a));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
